// File: rtl/out_port_arbiter_pkg.sv
// Shared types and constants for the output-port arbiter.
// The header byte it describes is only emitted when OUT_ARB_HDR_EN is defined.
package out_arb_pkg;

   localparam int NREQ   = 4;
   localparam int DATA_W = 16;
   localparam int BYTE_W = 8;
   localparam logic [3:0] HDR_TAG = 4'hA;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HDR  = 3'd1,
      ST_LO   = 3'd2,
      ST_HI   = 3'd3,
      ST_GAP  = 3'd4
   } state_t;

   // Binary index of a one-hot channel vector (zero when nothing is set).
   function automatic logic [1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
      logic [1:0] idx;
      idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (oh[i]) idx = idx | 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/out_port_arbiter_if.sv
// Channel request bus and serialized byte stream of the output-port arbiter.
// master: request sources and byte sink; slave: the arbiter.
interface out_port_arbiter_if;
   import out_arb_pkg::*;

   logic [NREQ-1:0]          req_valid;
   logic [NREQ*DATA_W-1:0]   req_data;
   logic [NREQ-1:0]          req_ready;
   logic                     out_ready;
   logic [BYTE_W-1:0]        byte_out;
   logic                     byte_stb;
   logic                     byte_last;
   logic [1:0]               chan_out;
   logic                     busy;

   modport master (
      output req_valid, req_data, out_ready,
      input  req_ready, byte_out, byte_stb, byte_last, chan_out, busy
   );

   modport slave (
      input  req_valid, req_data, out_ready,
      output req_ready, byte_out, byte_stb, byte_last, chan_out, busy
   );

endinterface

// File: rtl/out_port_arbiter_rr_pick.sv
// Combinational 4-way round-robin picker: the channel after ptr has top priority.
module rr_pick
   import out_arb_pkg::*;
(
   input  logic [NREQ-1:0] req,
   input  logic [1:0]      ptr,
   output logic [NREQ-1:0] grant
);

   logic [1:0] idx;

   // Walk ptr+1, ptr+2, ... (wrapping) and grant the first pending channel.
   always_comb begin
      grant = '0;
      idx   = ptr;
      for (int i = 0; i < NREQ; i++) begin
         idx = idx + 2'd1;
         if (req[idx] && (grant == '0)) grant[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/out_port_arbiter.sv
// Out-port arbiter: round-robin accepts 16-bit words from four channels and
// serializes each as low byte then high byte, with STB_GAP idle cycles after
// every frame. Defining OUT_ARB_HDR_EN prepends a tag byte (A0 | channel).
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a word; req_ready carries the round-robin pick
// HDR     | emitting tag byte (OUT_ARB_HDR_EN builds only)
// LO      | emitting word[7:0]
// HI      | emitting word[15:8], marked as last byte of the frame
// GAP     | inter-frame idle, down-counter runs to terminal count
module out_port_arbiter
   import out_arb_pkg::*;
#(
   parameter int STB_GAP = 0
)
(
   input  logic               clk,
   input  logic               rst,
   out_port_arbiter_if.slave  bus
);

   localparam logic [3:0] GAP_LOAD = 4'(STB_GAP);
`ifdef OUT_ARB_HDR_EN
   localparam state_t FIRST_ST = ST_HDR;
`else
   localparam state_t FIRST_ST = ST_LO;
`endif

   state_t          state, state_nx;
   logic [1:0]      ptr;
   logic [3:0]      gap_cnt;
   logic [DATA_W-1:0] word;
   logic [1:0]      chan_r;
   logic [NREQ-1:0] grant;
   logic            take;
   logic [1:0]      take_idx;

   rr_pick u_pick (
      .req   (bus.req_valid),
      .ptr   (ptr),
      .grant (grant)
   );

   // grant is a subset of req_valid, so any grant offered in IDLE is a transfer.
   assign take     = (state == ST_IDLE) && (gap_cnt == '0) && !rst && (|grant);
   assign take_idx = onehot_to_idx(grant);
   assign bus.chan_out = chan_r;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   // Next-state decode; every emitting state advances only when the sink accepts.
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (take) state_nx = FIRST_ST;
`ifdef OUT_ARB_HDR_EN
         ST_HDR:  if (bus.out_ready) state_nx = ST_LO;
`else
         ST_HDR:  state_nx = ST_IDLE;
`endif
         ST_LO:   if (bus.out_ready) state_nx = ST_HI;
         ST_HI:   if (bus.out_ready) state_nx = (GAP_LOAD != '0) ? ST_GAP : ST_IDLE;
         ST_GAP:  if (gap_cnt <= 4'd1) state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // Word capture, round-robin pointer and inter-frame gap down-counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr     <= 2'd3;
         gap_cnt <= '0;
         word    <= '0;
         chan_r  <= '0;
      end else begin
         if (take) begin
            word   <= bus.req_data[DATA_W*take_idx +: DATA_W];
            chan_r <= take_idx;
            ptr    <= take_idx;
         end
         if ((state == ST_HI) && bus.out_ready && (GAP_LOAD != '0))
            gap_cnt <= GAP_LOAD;
         else if ((state == ST_GAP) && (gap_cnt != '0))
            gap_cnt <= gap_cnt - 4'd1;
      end
   end

   // Output decode; everything is forced quiet while reset is asserted.
   always_comb begin
      bus.req_ready = '0;
      bus.byte_out  = '0;
      bus.byte_stb  = 1'b0;
      bus.byte_last = 1'b0;
      bus.busy      = 1'b0;
      if (!rst) begin
         bus.busy = (state != ST_IDLE);
         case (state)
            ST_IDLE: if (gap_cnt == '0) bus.req_ready = grant;
`ifdef OUT_ARB_HDR_EN
            ST_HDR: begin
               bus.byte_stb = 1'b1;
               bus.byte_out = {HDR_TAG, 2'b00, chan_r};
            end
`endif
            ST_LO: begin
               bus.byte_stb = 1'b1;
               bus.byte_out = word[7:0];
            end
            ST_HI: begin
               bus.byte_stb  = 1'b1;
               bus.byte_last = 1'b1;
               bus.byte_out  = word[15:8];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_out_port_arbiter.sv
// Bench for out_port_arbiter: dut0 with STB_GAP=0, dut1 with STB_GAP=2.
// Honors OUT_ARB_HDR_EN (header byte) when defined for the build.
module tb_out_port_arbiter;
   import out_arb_pkg::*;

`ifdef OUT_ARB_HDR_EN
   localparam int FLEN = 3;
`else
   localparam int FLEN = 2;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   out_port_arbiter_if bus0 ();
   out_port_arbiter_if bus1 ();

   out_port_arbiter #(.STB_GAP(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
   out_port_arbiter #(.STB_GAP(2)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   // stimulus state
   logic [15:0] srcq [4][$];
   logic [3:0]  vmask = 4'hF;
   logic        rst_nx = 1'b1;
   logic        or_nx  = 1'b0;
   logic [15:0] w1     = 16'h1111;
   logic [3:0]  acc [2];

   // frame-level reference model: list of bytes still to send per dut
   int          m_pos [2];
   int          m_gap [2];
   int          m_ptr [2];
   logic [1:0]  m_chan [2];
   logic [7:0]  m_bytes [2][3];

   logic [3:0]  mv;
   logic [63:0] md;
   logic        mor;
   logic [3:0]  e_rdy;
   logic [7:0]  e_byte;
   logic        e_stb, e_last, e_busy;
   logic [16:0] e_vec, a_vec;
   logic [15:0] mw;
   int          pc, mc, mn;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   // Per-cycle compare against the model, then advance the model by one clock.
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         mv  = (k == 0) ? bus0.req_valid : bus1.req_valid;
         md  = (k == 0) ? bus0.req_data  : bus1.req_data;
         mor = (k == 0) ? bus0.out_ready : bus1.out_ready;
         a_vec = (k == 0) ?
            {bus0.req_ready, bus0.byte_out, bus0.byte_stb, bus0.byte_last, bus0.chan_out, bus0.busy} :
            {bus1.req_ready, bus1.byte_out, bus1.byte_stb, bus1.byte_last, bus1.chan_out, bus1.busy};
         e_rdy = '0; e_byte = '0; e_stb = 1'b0; e_last = 1'b0; e_busy = 1'b0; pc = -1;
         if (!rst) begin
            if (m_pos[k] >= 0) begin
               e_stb  = 1'b1;
               e_byte = m_bytes[k][m_pos[k]];
               e_last = (m_pos[k] == FLEN - 1);
               e_busy = 1'b1;
            end else if (m_gap[k] > 0) begin
               e_busy = 1'b1;
            end else begin
               for (int j = 1; j <= 4; j++) begin
                  mc = (m_ptr[k] + j) % 4;
                  if (pc < 0 && mv[mc]) pc = mc;
               end
               if (pc >= 0) e_rdy[pc] = 1'b1;
            end
         end
         e_vec = {e_rdy, e_byte, e_stb, e_last, m_chan[k], e_busy};
         n_checks++;
         if (a_vec !== e_vec) begin
            n_errors++;
            $display("FAIL model_compare dut%0d cycle %0d: got {rdy,byte,stb,last,chan,busy}=%h, expected %h",
                     k, cyc, a_vec, e_vec);
         end
         acc[k] = '0;
         if (rst) begin
            m_pos[k] = -1; m_gap[k] = 0; m_ptr[k] = 3; m_chan[k] = 2'd0;
         end else if (m_pos[k] >= 0) begin
            if (mor) begin
               if (m_pos[k] == FLEN - 1) begin
                  m_pos[k] = -1;
                  m_gap[k] = (k == 0) ? 0 : 2;
               end else begin
                  m_pos[k]++;
               end
            end
         end else if (m_gap[k] > 0) begin
            m_gap[k]--;
         end else if (pc >= 0) begin
            mw = md[16*pc +: 16];
            mn = 0;
`ifdef OUT_ARB_HDR_EN
            m_bytes[k][0] = 8'hA0 | 8'(pc);
            mn = 1;
`endif
            m_bytes[k][mn]   = mw[7:0];
            m_bytes[k][mn+1] = mw[15:8];
            m_pos[k]  = 0;
            m_ptr[k]  = pc;
            m_chan[k] = 2'(pc);
            acc[k][pc] = 1'b1;
         end
      end
      cyc++;
   end

   // One clock: retire accepted words, drive staged inputs, settle past negedge.
   task automatic step();
      logic [3:0]  v;
      logic [63:0] d;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) if (acc[0][i]) void'(srcq[i].pop_front());
      if (acc[1][0]) w1 = w1 + 16'h1111;
      rst = rst_nx;
      bus0.out_ready = or_nx;
      bus1.out_ready = or_nx;
      v = '0; d = '0;
      for (int i = 0; i < 4; i++) begin
         if (srcq[i].size() > 0) begin
            v[i] = 1'b1;
            d[16*i +: 16] = srcq[i][0];
         end
      end
      bus0.req_valid = v & vmask;
      bus0.req_data  = d;
      bus1.req_valid = 4'b0001;
      bus1.req_data  = {48'h0, w1};
      @(negedge clk);
      #1;
   endtask

   logic [3:0] g_val [8];
   int         g_cyc [8];
   int         r1_cyc [8];
   int         ng, nr1;
   logic [31:0] pat;

   initial begin
      for (int k = 0; k < 2; k++) begin
         m_pos[k] = -1; m_gap[k] = 0; m_ptr[k] = 3; m_chan[k] = 2'd0; acc[k] = '0;
         for (int b = 0; b < 3; b++) m_bytes[k][b] = '0;
      end
      for (int i = 0; i < 8; i++) begin g_val[i] = '0; g_cyc[i] = 0; r1_cyc[i] = 0; end
      bus0.req_valid = '0; bus0.req_data = '0; bus0.out_ready = 1'b0;
      bus1.req_valid = '0; bus1.req_data = '0; bus1.out_ready = 1'b0;

      // reset state
      rst_nx = 1'b1; or_nx = 1'b0;
      step(); step();
      chk("rst_ready", bus0.req_ready, 0);
      chk("rst_stb", bus0.byte_stb, 0);
      chk("rst_last", bus0.byte_last, 0);
      chk("rst_byte", bus0.byte_out, 0);
      chk("rst_busy", bus0.busy, 0);
      chk("rst_chan", bus0.chan_out, 0);

      // single word on channel 2
      rst_nx = 1'b0; or_nx = 1'b1;
      srcq[2].push_back(16'hBEEF);
      step();
      chk("beef_ready", bus0.req_ready, 4'b0100);
`ifdef OUT_ARB_HDR_EN
      step();
      chk("beef_hdr", bus0.byte_out, 8'hA2);
`endif
      step();
      chk("beef_lo_stb", bus0.byte_stb, 1);
      chk("beef_lo_byte", bus0.byte_out, 8'hEF);
      chk("beef_lo_last", bus0.byte_last, 0);
      step();
      chk("beef_hi_byte", bus0.byte_out, 8'hBE);
      chk("beef_hi_last", bus0.byte_last, 1);
      chk("beef_hi_chan", bus0.chan_out, 2);
      step();
      chk("beef_idle_busy", bus0.busy, 0);
      chk("beef_idle_byte", bus0.byte_out, 0);

      // sink stall while the low byte is on the pins
      srcq[0].push_back(16'hBEEF);
      step();
      chk("stall_ready", bus0.req_ready, 4'b0001);
`ifdef OUT_ARB_HDR_EN
      step();
      chk("stall_hdr", bus0.byte_out, 8'hA0);
`endif
      or_nx = 1'b0;
      for (int t = 0; t < 3; t++) begin
         step();
         chk("stall_hold_byte", bus0.byte_out, 8'hEF);
         chk("stall_hold_stb", bus0.byte_stb, 1);
         chk("stall_hold_last", bus0.byte_last, 0);
      end
      or_nx = 1'b1;
      step();
      chk("stall_release_byte", bus0.byte_out, 8'hEF);
      step();
      chk("stall_hi_byte", bus0.byte_out, 8'hBE);
      chk("stall_hi_last", bus0.byte_last, 1);
      step();

      // all four channels pending from reset
      rst_nx = 1'b1; step(); rst_nx = 1'b0;
      srcq[0].push_back(16'h1000); srcq[0].push_back(16'h1001);
      srcq[1].push_back(16'h2000); srcq[2].push_back(16'h3000); srcq[3].push_back(16'h4000);
      ng = 0; nr1 = 0;
      for (int t = 1; t <= 20; t++) begin
         step();
         if (bus0.req_ready != '0 && ng < 8) begin g_val[ng] = bus0.req_ready; g_cyc[ng] = t; ng++; end
         if (bus1.req_ready != '0 && nr1 < 8) begin r1_cyc[nr1] = t; nr1++; end
         if (t == FLEN + 2 || t == FLEN + 3) begin
            chk("gap_busy", bus1.busy, 1);
            chk("gap_no_ready", bus1.req_ready, 0);
         end
      end
      chk("grant_count", 32'(ng), 5);
      for (int i = 0; i < 5; i++) chk("grant_order", g_val[i], 4'b0001 << (i % 4));
      for (int i = 0; i < 4; i++) chk("grant_spacing", 32'(g_cyc[i+1] - g_cyc[i]), FLEN + 1);
      for (int i = 0; i < 3; i++) chk("gap_spacing", 32'(r1_cyc[i+1] - r1_cyc[i]), FLEN + 3);

      // reset in the middle of a frame
      srcq[3].push_back(16'hC0DE);
      step();
      chk("midrst_ready", bus0.req_ready, 4'b1000);
      step();
      rst_nx = 1'b1;
      step();
      chk("midrst_stb", bus0.byte_stb, 0);
      chk("midrst_byte", bus0.byte_out, 0);
      chk("midrst_busy", bus0.busy, 0);
      chk("midrst_ready0", bus0.req_ready, 0);
      rst_nx = 1'b0;
      step();
      chk("postrst_stb", bus0.byte_stb, 0);
      chk("postrst_busy", bus0.busy, 0);
      chk("postrst_chan", bus0.chan_out, 0);
      for (int i = 0; i < 4; i++) srcq[i].push_back(16'h5A00 + 16'(i));
      step();
      chk("postrst_first", bus0.req_ready, 4'b0001);
      for (int t = 0; t < 16; t++) step();

      // valid withdrawn before acceptance
      vmask = 4'h0;
      srcq[1].push_back(16'h5555);
      step();
      chk("withdrawn_ready", bus0.req_ready, 0);
      chk("withdrawn_busy", bus0.busy, 0);
      vmask = 4'hF;
      step();
      chk("restored_ready", bus0.req_ready, 4'b0010);
      for (int t = 0; t < 4; t++) step();

`ifdef OUT_ARB_HDR_EN
      srcq[1].push_back(16'h1234);
      step();
      chk("hdr_ready", bus0.req_ready, 4'b0010);
      step();
      chk("hdr_tag", bus0.byte_out, 8'hA1);
      chk("hdr_tag_last", bus0.byte_last, 0);
      step();
      chk("hdr_lo", bus0.byte_out, 8'h34);
      step();
      chk("hdr_hi", bus0.byte_out, 8'h12);
      chk("hdr_hi_last", bus0.byte_last, 1);
      step();
`endif

      // mixed traffic with irregular sink back-pressure, model-checked only
      pat = 32'hB5D3_6E29;
      srcq[0].push_back(16'hA001); srcq[0].push_back(16'hA002); srcq[0].push_back(16'hA003);
      srcq[1].push_back(16'hB001); srcq[1].push_back(16'hB002);
      srcq[2].push_back(16'hC001);
      srcq[3].push_back(16'hD001); srcq[3].push_back(16'hD002);
      for (int t = 0; t < 60; t++) begin
         or_nx = pat[t % 32];
         if (t == 10) srcq[2].push_back(16'hC002);
         step();
      end
      or_nx = 1'b1;
      for (int t = 0; t < 20; t++) step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/out_port_arbiter.md
OUT_PORT_ARBITER -- requirements
Module: out_port_arbiter

Interface
REQ-001 Parameter: STB_GAP, 0, idle cycles inserted after each frame before next grant (0..15).
REQ-002 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  reset; synchronous, active-high.
REQ-004 Port: req_valid  in  4  per-channel word-pending flag; channel i held until accepted.
REQ-005 Port: req_data  in  64  channel i word at [16i+15:16i].
REQ-006 Port: req_ready  out  4  one-hot accept; transfer when req_valid[i] & req_ready[i].
REQ-007 Port: out_ready  in  1  pin-side sink accepts current byte this cycle.
REQ-008 Port: byte_out  out  8  serialized byte; 8'h00 whenever byte_stb=0.
REQ-009 Port: byte_stb  out  1  byte_out valid.
REQ-010 Port: byte_last  out  1  final byte of frame; only with byte_stb.
REQ-011 Port: chan_out  out  2  channel of frame in progress; held from grant through last byte.
REQ-012 Port: busy  out  1  high in every state except IDLE.

Function
REQ-013 States: IDLE, HDR (macro only), LO, HI, GAP.
REQ-014 IDLE with gap counter zero: req_ready driven combinationally = round-robin pick of req_valid, priority starting at ptr+1 mod 4; all-zero if no valid.
REQ-015 On transfer: capture 16-bit word, chan_out<=granted, ptr<=granted, go to LO (HDR if macro defined).
REQ-016 Latency: word accepted in cycle N -> first byte_stb in cycle N+1.
REQ-017 LO: byte_stb=1, byte_out=word[7:0]; on out_ready -> HI, else hold all outputs.
REQ-018 HI: byte_stb=1, byte_last=1, byte_out=word[15:8]; on out_ready -> GAP if STB_GAP>0 (counter loaded STB_GAP), else IDLE.
REQ-019 GAP: counter decrements each cycle; at 1 -> IDLE; no req_ready asserted.
REQ-020 Throughput with STB_GAP=0, out_ready=1: one word per 3 cycles (4 with header).
REQ-021 req_ready is zero in every state except IDLE; new valids arriving mid-frame wait.
REQ-022 Valid deasserted before acceptance: not an error; pick recomputed each cycle.
REQ-023 ptr wraps 3 -> 0; single active channel granted back-to-back without starvation check.

Reset
REQ-024 rst high: state<=IDLE, ptr<=3 (channel 0 first), gap counter<=0, word<=0, chan_out<=0.
REQ-025 During rst: req_ready=0, byte_stb=0, byte_last=0, byte_out=0, busy=0.
REQ-026 rst mid-frame: frame dropped, no further bytes; next grant follows reset pointer.

Configuration
REQ-027 Macro OUT_ARB_HDR_EN defined: HDR state precedes LO emitting byte_out=8'hA0|chan_out, byte_stb=1, byte_last=0, advance on out_ready.
REQ-028 Macro undefined: HDR state absent; frame is exactly two bytes.

Structure
REQ-029 Package out_arb_pkg: state enum, NREQ=4, DATA_W=16, BYTE_W=8, HDR_TAG=4'hA.
REQ-030 Sub-module rr_pick: combinational 4-way round-robin picker (req, ptr -> one-hot grant).
REQ-031 Target size 120-400 lines RTL total.

Verification
REQ-032 ch2 valid, 16'hBEEF, out_ready=1 -> req_ready=4'b0100 cycle N; N+1 stb 8'hEF; N+2 stb 8'hBE, last=1, chan_out=2.
REQ-033 All four valid from reset, continuous -> grant order 0,1,2,3,0; ready pulses 3 cycles apart.
REQ-034 out_ready=0 for 3 cycles in LO -> byte_out held 8'hEF, stb held, HI entered only after out_ready=1.
REQ-035 rst during HI -> next cycle IDLE, all outputs zero; subsequent all-valid grants channel 0 first.
REQ-036 OUT_ARB_HDR_EN defined, ch1 16'h1234 -> bytes 8'hA1, 8'h34, 8'h12 (last on 8'h12).
REQ-037 STB_GAP=2, ch0 always valid -> ready pulses every 5 cycles, busy high during GAP.
